bcp_imp_scheduler: RTL and testbench

//  Sequences implied literals from the BCP clause evaluators into the assignment datapath, one per handshake.

---
 rtl/bcp_imp_scheduler.sv | 146 ++++++++++++++
 tb/tb_bcp_imp_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_imp_scheduler.sv
// Implication scheduler for BCP: collects implied literals into a pending bitmap,
// issues them highest-index first through a valid/ready offer register, and flags
// opposite-polarity implications as a conflict.
module bcp_imp_scheduler #(
    parameter int unsigned VAR_NUM     = 8,
    parameter int unsigned VAR_NUM_LOG = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   start,
    input  logic [VAR_NUM-1:0]     imp_valid_i,
    input  logic [VAR_NUM-1:0]     imp_val_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VAR_NUM_LOG-1:0] out_var,
    output logic                   out_val,
    output logic                   busy,
    output logic                   done,
    output logic                   conflict,
    output logic [VAR_NUM_LOG-1:0] conflict_var,
    output logic [VAR_NUM_LOG:0]   issue_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StConflict} state_e;

    state_e                 state_q, state_d;
    logic [VAR_NUM-1:0]     pend_q, pend_d;
    logic [VAR_NUM-1:0]     pol_q, pol_d;
    logic [VAR_NUM-1:0]     asg_q, asg_d;
    logic                   out_valid_q, out_valid_d;
    logic [VAR_NUM_LOG-1:0] out_var_q, out_var_d;
    logic                   out_val_q, out_val_d;
    logic [VAR_NUM_LOG:0]   cnt_q, cnt_d;
    logic [VAR_NUM_LOG-1:0] cvar_q, cvar_d;

    logic                   samp;
    logic [VAR_NUM-1:0]     known;
    logic [VAR_NUM-1:0]     conf_bits;
    logic [VAR_NUM-1:0]     new_bits;
    logic                   any_conf;
    logic [VAR_NUM_LOG-1:0] pend_idx;
    logic [VAR_NUM_LOG-1:0] conf_idx;
    logic                   accept;
    logic                   load;

    // Strobe classification and highest-index selection on registered state
    always_comb begin
        samp      = (state_q == StIdle) || (state_q == StRun);
        known     = pend_q | asg_q;
        conf_bits = samp ? (imp_valid_i & known & (imp_val_i ^ pol_q)) : '0;
        new_bits  = samp ? (imp_valid_i & ~known) : '0;
        any_conf  = |conf_bits;
        pend_idx  = '0;
        conf_idx  = '0;
        for (int i = 0; i < int'(VAR_NUM); i++) begin
            if (pend_q[i]) pend_idx = VAR_NUM_LOG'(i);
            if (conf_bits[i]) conf_idx = VAR_NUM_LOG'(i);
        end
        accept = out_valid_q & out_ready;
        // A conflicting cycle never loads a new offer
        load   = (state_q == StRun) && !any_conf && (!out_valid_q || out_ready) && (|pend_q);
    end

    // Next-state logic for FSM, bitmaps, offer register and counters
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q | new_bits;
        pol_d       = (pol_q & ~new_bits) | (imp_val_i & new_bits);
        asg_d       = asg_q;
        out_valid_d = out_valid_q;
        out_var_d   = out_var_q;
        out_val_d   = out_val_q;
        cnt_d       = cnt_q;
        cvar_d      = cvar_q;

        if (accept) begin
            out_valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end

        if (load) begin
            out_valid_d      = 1'b1;
            out_var_d        = pend_idx;
            out_val_d        = pol_q[pend_idx];
            pend_d[pend_idx] = 1'b0;
            asg_d[pend_idx]  = 1'b1;
        end

        unique case (state_q)
            StIdle, StRun: begin
                if (any_conf) begin
                    state_d     = StConflict;
                    cvar_d      = conf_idx;
                    pend_d      = '0;
                    out_valid_d = 1'b0;
                end else if (state_q == StIdle) begin
                    if (start) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end
                end else if ((pend_q == '0) && !out_valid_q && (imp_valid_i == '0)) begin
                    state_d = StDone;
                end
            end
            StDone:     state_d = StIdle;
            StConflict: state_d = StConflict;
            default:    state_d = StIdle;
        endcase
    end

    // State registers; rst and clr both return the block to a clean idle round
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            pol_q       <= '0;
            asg_q       <= '0;
            out_valid_q <= 1'b0;
            out_var_q   <= '0;
            out_val_q   <= 1'b0;
            cnt_q       <= '0;
            cvar_q      <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pol_q       <= pol_d;
            asg_q       <= asg_d;
            out_valid_q <= out_valid_d;
            out_var_q   <= out_var_d;
            out_val_q   <= out_val_d;
            cnt_q       <= cnt_d;
            cvar_q      <= cvar_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_var      = out_var_q;
    assign out_val      = out_val_q;
    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign conflict     = (state_q == StConflict);
    assign conflict_var = cvar_q;
    assign issue_cnt    = cnt_q;

endmodule

// File: tb/tb_bcp_imp_scheduler.sv
// Directed bench for bcp_imp_scheduler: ordering, stall, conflict, duplicates and reset.
module tb_bcp_imp_scheduler;

    logic       clk = 1'b0;
    logic       rst, clr, start, out_ready;
    logic [7:0] imp_valid_i, imp_val_i;
    logic       out_valid, out_val, busy, done, conflict;
    logic [2:0] out_var, conflict_var;
    logic [3:0] issue_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bcp_imp_scheduler #(.VAR_NUM(8), .VAR_NUM_LOG(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .start        (start),
        .imp_valid_i  (imp_valid_i),
        .imp_val_i    (imp_val_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_var      (out_var),
        .out_val      (out_val),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .conflict_var (conflict_var),
        .issue_cnt    (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v, input logic [7:0] p);
        imp_valid_i = v;
        imp_val_i   = p;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b1; out_ready = 1'b1;
        strobe(8'hff, 8'hff);
        tick(); tick();
        // 1: reset with strobes/start active
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conf", conflict, 0);
        check("rst_cnt", issue_cnt, 0);
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        strobe(8'h00, 8'h00);
        tick();

        // 2: ordering of seeds 1,5,3
        strobe(8'b0010_1010, 8'hff);
        tick();
        strobe(8'h00, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ord_busy", busy, 1);
        check("ord_cnt0", issue_cnt, 0);
        out_ready = 1'b1;
        tick();
        check("ord_v5", out_valid, 1);
        check("ord_var5", out_var, 5);
        check("ord_val5", out_val, 1);
        tick();
        check("ord_var3", out_var, 3);
        check("ord_cnt1", issue_cnt, 1);
        tick();
        check("ord_var1", out_var, 1);
        check("ord_val1", out_val, 1);
        tick();
        check("ord_empty", out_valid, 0);
        check("ord_cnt3", issue_cnt, 3);
        check("ord_nodone", done, 0);
        tick();
        check("ord_done", done, 1);
        check("ord_busy0", busy, 0);
        tick();
        check("ord_done_pulse", done, 0);
        out_ready = 1'b0;

        // 1b: clr mid-RUN with an offer held, strobes/start active
        do_clr();
        strobe(8'h01, 8'h00);
        tick();
        strobe(8'h00, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("clr_pre_valid", out_valid, 1);
        clr = 1'b1; start = 1'b1;
        strobe(8'hf0, 8'h0f);
        tick();
        check("clr_valid", out_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_cnt", issue_cnt, 0);
        clr = 1'b0; start = 1'b0;
        strobe(8'h00, 8'h00);
        do_clr();

        // 3: stall on var 2, var 7 strobed meanwhile
        strobe(8'h04, 8'h00);
        tick();
        strobe(8'h00, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("stall_var2", out_var, 2);
        check("stall_val2", out_val, 0);
        strobe(8'h80, 8'h80);
        tick();
        strobe(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("stall_hold_var", out_var, 2);
            check("stall_hold_valid", out_valid, 1);
            tick();
        end
        check("stall_last_var", out_var, 2);
        out_ready = 1'b1;
        tick();
        check("stall_var7", out_var, 7);
        check("stall_val7", out_val, 1);
        check("stall_cnt1", issue_cnt, 1);
        tick();
        check("stall_cnt2", issue_cnt, 2);
        tick();
        check("stall_done", done, 1);
        out_ready = 1'b0;
        tick();
        do_clr();

        // 4: var 4 issued val 0, then strobed val 1
        strobe(8'h10, 8'h00);
        tick();
        strobe(8'h00, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        check("conf_var4", out_var, 4);
        strobe(8'h10, 8'h10);
        tick();
        strobe(8'h00, 8'h00);
        check("conf_flag", conflict, 1);
        check("conf_var", conflict_var, 4);
        check("conf_cnt", issue_cnt, 1);
        check("conf_valid", out_valid, 0);
        strobe(8'h02, 8'h02);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("conf_hold", conflict, 1);
            check("conf_nodone", done, 0);
            check("conf_ignored", out_valid, 0);
        end
        strobe(8'h00, 8'h00);
        start = 1'b0;
        out_ready = 1'b0;
        do_clr();
        check("conf_clr", conflict, 0);
        check("conf_clr_var", conflict_var, 0);

        // 6: same-cycle conflicts on vars 2 and 6
        strobe(8'h44, 8'h00);
        tick();
        strobe(8'h44, 8'h44);
        tick();
        strobe(8'h00, 8'h00);
        check("mc_flag", conflict, 1);
        check("mc_var", conflict_var, 6);
        do_clr();

        // 5: duplicate var 6 while pending and after issue
        strobe(8'h40, 8'h40);
        tick();
        tick();
        strobe(8'h00, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("dup_var6", out_var, 6);
        check("dup_valid", out_valid, 1);
        strobe(8'h40, 8'h40);
        out_ready = 1'b1;
        tick();
        strobe(8'h00, 8'h00);
        check("dup_empty", out_valid, 0);
        check("dup_nconf", conflict, 0);
        tick();
        check("dup_done", done, 1);
        check("dup_cnt", issue_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
